mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF stage) and the data access of the MEM stage in the MIPS pipeline.
- Sequences each access through a req/ack handshake with variable wait states.
- Generates PC_load, which holds the PC and IF/ID, and pipe_stall, which freezes ID/EX, EX/MEM and MEM/WB, so the datapath advances only when its memory traffic has completed.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width
MAX_WAIT, 15, maximum cycles a request may wait for mem_ack before it is aborted

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
if_req  in  1  IF stage requests an instruction at if_addr
if_addr  in  ADDR_W  current PC
flush  in  1  taken branch/jump in ID; discard fetched or in-flight instruction
if_rdata  out  DATA_W  buffered instruction
if_valid  out  1  if_rdata holds a valid instruction
PC_load  out  1  PC and IF/ID load enable
dm_read  in  1  MEM stage load (MemRead)
dm_write  in  1  MEM stage store (MemWrite)
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, registered
dm_done  out  1  one-cycle pulse: data access complete
pipe_stall  out  1  freeze all pipeline registers past IF/ID
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completes the current request this cycle
timeout_err  out  1  sticky: a request exceeded MAX_WAIT

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, if_rdata, if_valid, dm_rdata, dm_done, timeout_err.
  - Instruction buffer empty, discard flag clear, wait counter 0.
  - A reset during an access drops mem_req at that edge; the result is lost.
- States: IDLE, DATA, DRET, INST.
- IDLE transitions:
  - dm_read|dm_write -> DATA. Data has priority.
  - Else if_req & ~if_valid -> INST.
  - On entry to either state, register mem_addr, mem_we and mem_wdata.
  - If dm_read and dm_write are both 1, treat the access as a write.
- DATA:
  - mem_req=1; addr/we/wdata held stable.
  - On mem_ack: dm_rdata<=mem_rdata (loads only; stores leave dm_rdata unchanged), then -> DRET.
- DRET: dm_done=1 for exactly one cycle, then -> IDLE.
- INST:
  - mem_req=1, mem_we=0.
  - On mem_ack: if the discard flag is set, drop the data and clear the flag; otherwise if_rdata<=mem_rdata and if_valid<=1. Then -> IDLE.
- Combinational stall and load logic:
  - pipe_stall = (dm_read|dm_write) & (state!=DRET).
  - PC_load = (if_valid | flush) & ~pipe_stall.
- Buffer consumption: if_valid clears on any edge where PC_load=1, or where flush=1.
- Flush while in INST: sets the discard flag. The discard flag never persists past the ack or the abort of the fetch.
- Latency (zero wait states, mem_ack in the first req cycle):
  - Data access: dm_read seen in IDLE at cycle 0; cycle 1 DATA; cycle 2 DRET. pipe_stall is high in cycles 0-1 and low in cycle 2.
  - Instruction fetch: if_valid=1 two cycles after the IDLE decision.
- Each additional wait state adds one cycle.
- Timeout:
  - The wait counter resets on entry to DATA or INST and increments each cycle without mem_ack.
  - If the counter reaches MAX_WAIT without mem_ack: timeout_err<=1 (sticky until rst) and mem_req drops.
  - A data access then goes to DRET with dm_rdata<=0, so the pipeline cannot deadlock.
  - A fetch goes to IDLE with if_valid=0.
- An in-flight fetch is never preempted. A data request arriving during INST waits for INST to finish; pipe_stall stays high meanwhile.
- mem_ack outside DATA/INST is ignored.

Test Plan:
1. Zero-wait fetches: if_req=1, if_addr=0x00, mem_ack tied 1, mem_rdata=0x20080005 -> mem_req in cycle 1, if_valid=1 with if_rdata=0x20080005 in cycle 2, PC_load=1 in cycle 2.
2. Load with 3 wait states: dm_read=1, dm_addr=0x40, mem_ack on the 4th DATA cycle with mem_rdata=0xDEADBEEF -> pipe_stall high for 5 cycles, then dm_done=1 and dm_rdata=0xDEADBEEF, PC_load=0 throughout the stall.
3. Conflict: dm_write asserted while INST is waiting 2 cycles -> fetch completes first (if_valid=1, PC_load=0), then DATA with mem_we=1, mem_wdata=dm_wdata, then dm_done and PC_load=1.
4. Flush during fetch: flush=1 while INST is waiting -> instruction returned at ack is dropped (if_valid stays 0), PC_load=1 in the flush cycle, next fetch uses the new if_addr.
5. Timeout: mem_ack held 0, dm_read=1, MAX_WAIT=15 -> after 15 DATA cycles mem_req=0, timeout_err=1, dm_done pulse with dm_rdata=0, timeout_err remains 1 until rst.
6. Reset mid-access: rst=1 during DATA -> next cycle mem_req=0, state IDLE, all outputs 0, and a subsequent mem_ack has no effect.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between the IF stage (instruction
//   fetch) and the MEM stage (loads/stores) of a 5-stage MIPS pipeline.
//   Every access is sequenced through a req/ack handshake that tolerates any
//   number of wait states, with a watchdog that aborts a request after
//   MAX_WAIT cycles without mem_ack.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   if_req/if_addr      IF stage fetch request at the current PC
//   flush               taken branch/jump in ID, kill the fetched instruction
//   if_rdata/if_valid   one-entry instruction buffer feeding IF/ID
//   PC_load             load enable for PC and IF/ID
//   dm_read/dm_write    MEM stage load/store request
//   dm_addr/dm_wdata    MEM stage address and store data
//   dm_rdata/dm_done    registered load data, one-cycle completion pulse
//   pipe_stall          freeze ID/EX, EX/MEM, MEM/WB
//   mem_*               single-port memory request/response
//   timeout_err         sticky: some request hit the MAX_WAIT watchdog
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              PC_load,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              pipe_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err
);

    // Counter only needs to reach MAX_WAIT-1; the cycle after that is the abort.
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {IDLE, DATA, DRET, INST} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              timeout_q, timeout_d;
    logic              discard_q, discard_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic dm_any;
    logic wait_expired;

    assign dm_any       = dm_read | dm_write;
    // DRET is the one cycle the MEM stage result is ready, so the pipe may move.
    assign pipe_stall   = dm_any & (state_q != DRET);
    assign PC_load      = (if_valid_q | flush) & ~pipe_stall;
    assign wait_expired = (wait_cnt_q == CNT_W'(MAX_WAIT - 1));

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        if_valid_d  = if_valid_q;
        dm_rdata_d  = dm_rdata_q;
        timeout_d   = timeout_q;
        discard_d   = discard_q;
        wait_cnt_d  = wait_cnt_q;

        // IF/ID took the instruction, or a redirect made it stale.
        if (PC_load || flush) begin
            if_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (dm_any) begin
                    state_d     = DATA;
                    mem_addr_d  = dm_addr;
                    mem_we_d    = dm_write;   // read+write together is a store
                    mem_wdata_d = dm_wdata;
                    wait_cnt_d  = '0;
                end else if (if_req && !if_valid_q) begin
                    state_d     = INST;
                    mem_addr_d  = if_addr;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                    wait_cnt_d  = '0;
                    // A redirect in the launch cycle makes if_addr stale already.
                    discard_d   = flush;
                end
            end
            DATA: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    state_d = DRET;
                end else if (wait_expired) begin
                    // Abort but still complete so the pipeline cannot deadlock.
                    timeout_d  = 1'b1;
                    dm_rdata_d = '0;
                    state_d    = DRET;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            DRET: begin
                state_d = IDLE;
            end
            INST: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (mem_ack) begin
                    if (!(discard_q || flush)) begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end
                    discard_d = 1'b0;
                    state_d   = IDLE;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    discard_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            timeout_q   <= 1'b0;
            discard_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_rdata_q  <= dm_rdata_d;
            timeout_q   <= timeout_d;
            discard_q   <= discard_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // mem_req follows state so a reset or abort drops it at the same edge.
    assign mem_req     = (state_q == DATA) || (state_q == INST);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign if_valid    = if_valid_q;
    assign dm_rdata    = dm_rdata_q;
    assign dm_done     = (state_q == DRET);
    assign timeout_err = timeout_q;

endmodule
